// File: rtl/lsu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_pkg : shared opcodes, func3 codes, size/state enums, causes  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    function automatic logic [3:0] size_bytes(input size_e sz);
        return 4'd1 << sz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_align : byte enables, store lane shift, load extract/extend  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NB    = XLEN / 8,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [1:0]       size,
    input  logic [OFF_W-1:0] offset,
    input  logic             is_unsigned,
    input  logic [XLEN-1:0]  st_data,
    input  logic [XLEN-1:0]  ld_data,
    output logic [NB-1:0]    be,
    output logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  ld_ext
);

    logic [NB-1:0]   w_size_mask;
    logic [XLEN-1:0] w_data_mask;
    logic [XLEN-1:0] w_shifted;

    always_comb begin
        w_size_mask = '1;
        w_data_mask = '1;
        case (size_e'(size))
            SZ_B: begin
                w_size_mask = NB'(1);
                w_data_mask = XLEN'(64'hFF);
            end
            SZ_H: begin
                w_size_mask = NB'(3);
                w_data_mask = XLEN'(64'hFFFF);
            end
            SZ_W: begin
                w_size_mask = NB'(15);
                w_data_mask = XLEN'(64'hFFFF_FFFF);
            end
            default: begin
                w_size_mask = '1;
                w_data_mask = '1;
            end
        endcase

        be        = w_size_mask << offset;
        wdata     = (st_data & w_data_mask) << {offset, 3'b000};
        w_shifted = ld_data >> {offset, 3'b000};

        // Casting a signed slice up to XLEN sign-extends; unsigned slices zero-extend.
        case (size_e'(size))
            SZ_B:    ld_ext = is_unsigned ? XLEN'(w_shifted[7:0])  : XLEN'($signed(w_shifted[7:0]));
            SZ_H:    ld_ext = is_unsigned ? XLEN'(w_shifted[15:0]) : XLEN'($signed(w_shifted[15:0]));
            SZ_W:    ld_ext = is_unsigned ? XLEN'(w_shifted[31:0]) : XLEN'($signed(w_shifted[31:0]));
            default: ld_ext = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_pipe : handshaked RV64I load/store unit, one access in flight|
// | Option : LSU_MISALIGN_TRAP_EN traps misaligned accesses          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module lsu_pipe
    import lsu_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int ADDR_W    = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func3,
    input  logic [11:0]          imm,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic [REG_IDX_W-1:0] rd_idx,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [XLEN/8-1:0]    mem_be,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 wb_valid,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic                 st_done,
    output logic                 exc_valid,
    output logic [1:0]           exc_cause,
    output logic [ADDR_W-1:0]    exc_addr
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    state_e                r_state;
    logic [ADDR_W-1:0]     r_addr;
    size_e                 r_size;
    logic                  r_unsigned;
    logic [REG_IDX_W-1:0]  r_rd;
    logic [XLEN-1:0]       r_st_data;
    logic                  r_is_store;
    logic                  r_in_ready;
    logic                  r_mem_req;
    logic                  r_wb_valid;
    logic [REG_IDX_W-1:0]  r_wb_rd;
    logic [XLEN-1:0]       r_wb_data;
    logic                  r_st_done;
    logic                  r_exc_valid;
    logic [1:0]            r_exc_cause;
    logic [ADDR_W-1:0]     r_exc_addr;

    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_illegal;
    size_e                 w_size;
    logic [ADDR_W-1:0]     w_eff;
    logic [OFF_W-1:0]      w_align_mask;
    logic [ADDR_W-1:0]     w_addr_cap;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                  w_misaligned;
`endif

    logic [NB-1:0]         w_be;
    logic [XLEN-1:0]       w_wdata;
    logic [XLEN-1:0]       w_ld_ext;

    always_comb begin
        w_is_load    = (opcode == OPC_LOAD);
        w_is_store   = (opcode == OPC_STORE);
        w_size       = size_e'(func3[1:0]);
        w_eff        = ADDR_W'(rs1_data + XLEN'($signed(imm)));
        w_align_mask = OFF_W'(size_bytes(w_size) - 4'd1);

        w_illegal = 1'b0;
        if (w_is_store)
            w_illegal = func3[2];
        else if (w_is_load)
            w_illegal = (func3 == 3'b111);
        // A 32-bit bus has no doubleword and no zero-extending word load.
        if ((XLEN == 32) && ((w_size == SZ_D) || (func3 == F3_WU)))
            w_illegal = 1'b1;

`ifdef LSU_MISALIGN_TRAP_EN
        w_misaligned = |(w_eff[OFF_W-1:0] & w_align_mask);
        w_addr_cap   = w_eff;
`else
        w_addr_cap   = {w_eff[ADDR_W-1:OFF_W], w_eff[OFF_W-1:0] & ~w_align_mask};
`endif
    end

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .size        (r_size),
        .offset      (r_addr[OFF_W-1:0]),
        .is_unsigned (r_unsigned),
        .st_data     (r_st_data),
        .ld_data     (mem_rdata),
        .be          (w_be),
        .wdata       (w_wdata),
        .ld_ext      (w_ld_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_size      <= SZ_B;
            r_unsigned  <= 1'b0;
            r_rd        <= '0;
            r_st_data   <= '0;
            r_is_store  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_mem_req   <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_st_done   <= 1'b0;
            r_exc_valid <= 1'b0;
            r_exc_cause <= '0;
            r_exc_addr  <= '0;
        end else begin
            r_wb_valid  <= 1'b0;
            r_st_done   <= 1'b0;
            r_exc_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && (w_is_load || w_is_store)) begin
                        if (w_illegal) begin
                            r_exc_valid <= 1'b1;
                            r_exc_cause <= CAUSE_ILLEGAL;
                            r_exc_addr  <= w_eff;
                        end
`ifdef LSU_MISALIGN_TRAP_EN
                        else if (w_misaligned) begin
                            r_exc_valid <= 1'b1;
                            r_exc_cause <= CAUSE_MISALIGN;
                            r_exc_addr  <= w_eff;
                        end
`endif
                        else begin
                            r_addr     <= w_addr_cap;
                            r_size     <= w_size;
                            r_unsigned <= func3[2];
                            r_rd       <= rd_idx;
                            r_st_data  <= rs2_data;
                            r_is_store <= w_is_store;
                            r_in_ready <= 1'b0;
                            r_mem_req  <= 1'b1;
                            r_state    <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        if (r_is_store) begin
                            r_st_done  <= 1'b1;
                            r_in_ready <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else if (mem_rvalid) begin
                            // Same-cycle grant and data: skip the wait state.
                            r_wb_data  <= w_ld_ext;
                            r_wb_rd    <= r_rd;
                            r_wb_valid <= 1'b1;
                            r_state    <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT_R;
                        end
                    end
                end
                ST_WAIT_R: begin
                    if (mem_rvalid) begin
                        r_wb_data  <= w_ld_ext;
                        r_wb_rd    <= r_rd;
                        r_wb_valid <= 1'b1;
                        r_state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_mem_req  <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_req & r_is_store;
    assign mem_addr  = r_mem_req ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem_be    = r_mem_req ? w_be : '0;
    assign mem_wdata = r_mem_req ? w_wdata : '0;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign st_done   = r_st_done;
    assign exc_valid = r_exc_valid;
    assign exc_cause = r_exc_cause;
    assign exc_addr  = r_exc_addr;

endmodule
`default_nettype wire

// File: doc/lsu_pipe.md
Name: lsu_pipe

Overview:
- Parametrised RV64I load/store unit. Sits between execute and the data-memory port.
- Per accepted instruction it:
  - computes the effective address rs1 + sext(imm);
  - drives a single-beat request/grant/rvalid memory handshake with byte enables and lane-shifted store data;
  - returns sign- or zero-extended load data to writeback.
- Replaces the earlier combinational-only load/store decoder with a handshaked, stallable FSM.

Parameters:
- XLEN, 64, register and data-bus width; legal values 32 or 64.
- ADDR_W, 32, memory address width.
- REG_IDX_W, 5, destination register index width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute presents a load/store
- in_ready  out  1  unit can accept (IDLE only)
- opcode  in  7  0000011 load, 0100011 store; any other value is ignored (in_ready still asserted, nothing accepted)
- func3  in  3  access size/sign
- imm  in  12  signed offset
- rs1_data  in  XLEN  base
- rs2_data  in  XLEN  store data
- rd_idx  in  REG_IDX_W  load destination
- mem_req  out  1  request valid
- mem_we  out  1  1 = store
- mem_addr  out  ADDR_W  bus-aligned address (low log2(XLEN/8) bits zero)
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  load data valid
- mem_rdata  in  XLEN  load data
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  REG_IDX_W  destination
- wb_data  out  XLEN  extended load data
- st_done  out  1  one-cycle store-complete pulse
- exc_valid  out  1  one-cycle exception pulse
- exc_cause  out  2  01 misaligned, 10 illegal func3
- exc_addr  out  ADDR_W  faulting effective address

Behaviour:
- Reset: asynchronous on rst_n low.
  - State = IDLE.
  - All outputs 0, except in_ready = 1.
  - All capture registers cleared.
- An in-flight access is abandoned on reset, with no completion pulse. The memory side must tolerate the dropped request.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE:
  - in_ready = 1.
  - On in_valid with a load/store opcode:
    - capture effective address (XLEN add, truncated to ADDR_W), func3, rd_idx, store data, is_store;
    - decode size: 000 B, 001 H, 010 W, 011 D; loads also 100 BU, 101 HU, 110 WU.
  - Exception cases:
    - illegal func3 (stores ≥100; loads 111; D/WU when XLEN = 32) → exc_valid next cycle with cause 10, stay IDLE;
    - misaligned (offset mod size ≠ 0) → cause 01 (see Optional Feature).
  - Otherwise go to REQ.
- REQ:
  - mem_req = 1, with mem_we/addr/be/wdata held stable until mem_gnt.
  - mem_be = size mask << offset.
  - mem_wdata = rs2 low bytes << (8 × offset).
  - On gnt:
    - store → st_done pulse the next cycle, go to IDLE;
    - load → go to WAIT_R.
- WAIT_R:
  - mem_rvalid before gnt is ignored.
  - On mem_rvalid: register rdata >> (8 × offset), extend per func3 (sign for B/H/W, zero for BU/HU/WU), go to RESP.
- RESP: wb_valid = 1 for exactly one cycle with wb_rd/wb_data, then IDLE.
- Latency:
  - store = 2 cycles + grant wait;
  - load = accept → req 1 cycle, + grant wait, + rvalid wait, + 1 cycle to wb.
- Throughput: one outstanding access, no pipelining of requests.
- gnt and rvalid in the same cycle while in REQ: treat as gnt followed immediately by rvalid; go directly to RESP.
- wb_data, wb_rd and exc_addr hold their last value when not pulsed.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses raise exc_valid (cause 01, exc_addr = effective address) and issue no memory request.
- Undefined: the low address bits are forced to size alignment (offset rounded down) and the access proceeds normally; cause 01 is never produced.

Decomposition:
- Shared package lsu_pkg:
  - opcode constants OPC_LOAD/OPC_STORE;
  - func3 constants;
  - size enum (B/H/W/D);
  - FSM state enum;
  - exception cause codes.
- One natural sub-module, lsu_align: combinational computation of byte-enable, store-data lane shift, and load extract/extend. Reused by the unit and by the bench's reference model.

Test Plan:
- SD, rs1=0x1000, imm=8, rs2=0x1122334455667788, gnt after 2 cycles → mem_addr=0x1008, mem_be=0xFF, mem_wdata=rs2, st_done one cycle after gnt.
- LB, address 0x2003, mem_rdata=0x00000000_80000000 → mem_be=0x08, wb_data=0xFFFFFFFFFFFFFF80; LBU at the same address → wb_data=0x80.
- LW, imm=-4 (0xFFC), rs1=0x3008 → addr 0x3004, be=0xF0; rdata upper word 0x7FFFFFFF → wb_data=0x000000007FFFFFFF.
- LH at 0x4001 with LSU_MISALIGN_TRAP_EN → exc_valid, cause 01, exc_addr=0x4001, no mem_req. Without the macro → request at 0x4000, be=0x03.
- Store with func3=100 → exc cause 10, no request, in_ready back to 1 the next cycle.
- rst_n low while in WAIT_R → mem_req, wb_valid and st_done all 0 immediately; in_ready = 1 after release; no wb pulse from the dropped load.
